// File: rtl/lagrange_up43.sv
// rtl/lagrange_up43.sv - 4/3 cubic Lagrange Farrow upsampler, Q8 arithmetic
// Optional output clamp to [-128,127] when LAGRANGE_UP43_SAT_EN is defined.
module lagrange_up43 (
    input  logic              clk,
    input  logic              reset,
    input  logic signed [7:0] x_in,
    output logic [3:0]        count_o,
    output logic              ena_in_o,
    output logic              ena_out_o,
    output logic [1:0]        phase_o,
    output logic signed [7:0] y_out,
    output logic              y_valid
);

    logic signed [7:0]  xb [4];
    logic signed [7:0]  s  [4];
    logic [7:0]         d1, d2, d3, d4;
    logic               v1, v2, v3, v4;
    logic signed [10:0] c0_2, c1_2, c2_2, c3_2;
    logic signed [10:0] h3, c1_3, c0_3;
    logic signed [10:0] h2, c0_4;

    logic [7:0]         lut_d;
    logic signed [19:0] e0, e1, e2, e3;
    logic signed [19:0] sum1, sum2, sum3;
    logic signed [19:0] p3, p2, p1;
    logic signed [10:0] h3_n, h2_n, yi;
    logic signed [7:0]  y_next;

    always_comb begin
        case (phase_o)
            2'd0:    lut_d = 8'd0;
            2'd1:    lut_d = 8'd192;
            2'd2:    lut_d = 8'd128;
            default: lut_d = 8'd64;
        endcase
    end

    // Each coefficient is one wide sum with a single arithmetic shift at the end.
    always_comb begin
        e0   = 20'(s[0]);
        e1   = 20'(s[1]);
        e2   = 20'(s[2]);
        e3   = 20'(s[3]);
        sum1 = 20'sd256 * e2 - 20'sd85 * e0 - 20'sd128 * e1 - 20'sd43 * e3;
        sum2 = 20'sd128 * e0 - 20'sd256 * e1 + 20'sd128 * e2;
        sum3 = 20'sd128 * e1 + 20'sd43 * e3 - 20'sd43 * e0 - 20'sd128 * e2;
        p3   = 20'(c3_2) * $signed({12'd0, d2});
        h3_n = 11'(p3 >>> 8) + c2_2;
        p2   = 20'(h3) * $signed({12'd0, d3});
        h2_n = 11'(p2 >>> 8) + c1_3;
        p1   = 20'(h2) * $signed({12'd0, d4});
        yi   = 11'(p1 >>> 8) + c0_4;
`ifdef LAGRANGE_UP43_SAT_EN
        if (yi > 11'sd127)
            y_next = 8'sd127;
        else if (yi < -11'sd128)
            y_next = -8'sd128;
        else
            y_next = 8'(yi);
`else
        y_next = 8'(yi);
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_o   <= '0;
            ena_in_o  <= 1'b0;
            ena_out_o <= 1'b0;
            phase_o   <= '0;
            for (int i = 0; i < 4; i++) begin
                xb[i] <= '0;
                s[i]  <= '0;
            end
            {d1, d2, d3, d4} <= '0;
            {v1, v2, v3, v4} <= '0;
            {c0_2, c1_2, c2_2, c3_2} <= '0;
            {h3, c1_3, c0_3, h2, c0_4} <= '0;
            y_out     <= '0;
            y_valid   <= 1'b0;
        end else begin
            count_o   <= (count_o == 4'd11) ? 4'd0 : count_o + 4'd1;
            ena_in_o  <= (count_o == 4'd3) || (count_o == 4'd7) || (count_o == 4'd11);
            ena_out_o <= (count_o == 4'd2) || (count_o == 4'd5) ||
                         (count_o == 4'd8) || (count_o == 4'd11);

            if (ena_in_o) begin
                xb[0] <= xb[1];
                xb[1] <= xb[2];
                xb[2] <= xb[3];
                xb[3] <= x_in;
            end

            // Snapshot reads pre-shift taps when both strobes coincide.
            v1 <= ena_out_o;
            if (ena_out_o) begin
                for (int i = 0; i < 4; i++) s[i] <= xb[i];
                d1      <= lut_d;
                phase_o <= phase_o + 2'd1;
            end

            v2   <= v1;
            d2   <= d1;
            c0_2 <= 11'(s[1]);
            c1_2 <= 11'(sum1 >>> 8);
            c2_2 <= 11'(sum2 >>> 8);
            c3_2 <= 11'(sum3 >>> 8);

            v3   <= v2;
            d3   <= d2;
            h3   <= h3_n;
            c1_3 <= c1_2;
            c0_3 <= c0_2;

            v4   <= v3;
            d4   <= d3;
            h2   <= h2_n;
            c0_4 <= c0_3;

            y_valid <= v4;
            if (v4) y_out <= y_next;
        end
    end

endmodule

// File: doc/lagrange_up43.md
# lagrange_up43

Fractional-rate upsampler converting one input stream to a 4/3-higher output rate using a cubic Lagrange Farrow interpolator. Frame of 12 clocks: 3 input samples accepted (every 4 clocks), 4 output samples produced (every 3 clocks). It is the rate-increasing counterpart of the team's 4-to-3 C-MOMS spline decimator and shares its clock-enable scheme and Q8 fixed-point arithmetic.

## Interface
- No parameters (tap length fixed at 4).
- clk  in  1  system clock, all registers rising-edge.
- reset  in  1  asynchronous, active-low; clears all state.
- x_in  in  8  signed input sample, sampled when ena_in is high.
- count_o  out  4  frame counter 0..11.
- ena_in_o  out  1  input-accept strobe.
- ena_out_o  out  1  output-compute strobe.
- phase_o  out  2  current phase index t.
- y_out  out  8  signed interpolated sample.
- y_valid  out  1  one-cycle pulse when y_out is updated.

## Operation
- count: 0..11, +1 per clk, 11 wraps to 0.
- ena_in: registered decode of count ∈ {3,7,11}; ena_out: registered decode of count ∈ {2,5,8,11}.
- Tap line xb[0..3] (xb[3] newest): on ena_in shift xb[i-1]<=xb[i], xb[3]<=x_in.
- On ena_out (stage S1): snapshot s[0..3]<=xb[0..3] (pre-shift values when ena_in is also high), latch d<=LUT[t], advance t 0→1→2→3→0.
- Phase LUT (Q8): t=0:0, t=1:192, t=2:128, t=3:64.
- S2 coefficients, each one sum followed by a single >>>8, 11-bit signed:
  - c0 = s1
  - c1 = (-85 s0 - 128 s1 + 256 s2 - 43 s3) >>> 8
  - c2 = (128 s0 - 256 s1 + 128 s2) >>> 8
  - c3 = (-43 s0 + 128 s1 - 128 s2 + 43 s3) >>> 8
- S3: h3 = ((c3·d) >>> 8) + c2; S4: h2 = ((h3·d) >>> 8) + c1; S5: yi = ((h2·d) >>> 8) + c0 (11-bit). d is carried along the pipeline with its sample.
- Products use 20-bit signed intermediates; d is unsigned 0..192 (zero-extended before multiply).
- S5 output conversion of yi to y_out per Configuration.
- Pipeline is free-running; a valid bit travels S1→S5 and drives y_valid.

## Timing
- Reset values: count=0, t=0, d=0, ena_in_o=0, ena_out_o=0, taps/snapshot/coefficients/pipeline=0, y_out=0, y_valid=0, phase_o=0.
- First ena_out is the cycle after count=2; first ena_in is the cycle after count=3.
- Latency: ena_out high in cycle k → y_out/y_valid updated at the edge ending cycle k+4 (visible cycle k+5); y_valid high exactly 1 cycle, 4 pulses per 12 clocks.
- Simultaneous ena_in/ena_out (cycle after count=11): snapshot takes pre-shift taps; the shift still happens.
- Reset mid-frame: all state cleared immediately; in-flight samples discarded, no y_valid until the 5th cycle after the first post-reset ena_out.
- x_in is ignored outside ena_in cycles.

## Configuration
- LAGRANGE_UP43_SAT_EN defined: yi clamped to [-128, 127] before driving y_out.
- Undefined: y_out = yi[7:0] (two's-complement wrap), no clamp logic.

## Test plan
- Reset: hold reset=0 for 3 clk with random x_in → all outputs 0; release → ena_out_o first high the cycle after count_o=2, ena_in_o the cycle after count_o=3.
- DC: x_in=100 constant for 3 frames → after the taps fill, every y_valid gives y_out=100 exactly at all four phases.
- Ramp: x_in +8 per accepted sample → y_out matches linear interpolation s1+8·d/256 within ±1 LSB for d=0,64,128,192.
- Strobe/latency: count y_valid over 120 clocks → exactly 40 pulses; each y_valid 5 cycles after its ena_out; phase_o sequence 0,1,2,3 repeating.
- Overshoot: taps −128,127,127,−128 at d=128 → y_out=127 with LAGRANGE_UP43_SAT_EN, y_out=yi[7:0] (≈ −98) without.
- Reset mid-operation at count=6 → outputs zero next edge; restart sequence identical to the first reset test.
